// File: rtl/pipe_buf_elastic_reg.sv
// Elastic valid/ready pipeline buffer register with flush-to-bubble and an occupancy count.
// PIPE_BUF_SKID_EN adds a skid entry so in_ready comes from a register; without it the buffer holds one entry.
module pipe_buf_elastic_reg #(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_main_nxt;
  logic             w_in_fire;
  logic             w_out_fire;

  assign out_valid  = (r_state != S_EMPTY);
  assign out_data   = r_main;
  assign occ        = r_state;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

`ifdef PIPE_BUF_SKID_EN
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_skid_nxt;

  assign in_ready = (r_state != S_TWO);

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = in_data;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = in_data;
        end else if (w_in_fire) begin
          w_state_nxt = S_TWO;
          w_skid_nxt  = in_data;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = BUBBLE_VAL;
        end
      end
      S_TWO: begin
        if (w_out_fire) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = r_skid;
          w_skid_nxt  = BUBBLE_VAL;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
        w_main_nxt  = BUBBLE_VAL;
        w_skid_nxt  = BUBBLE_VAL;
      end
    endcase
    // Flush wins over everything; a same-cycle out_fire was already delivered.
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = BUBBLE_VAL;
      w_skid_nxt  = BUBBLE_VAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid <= BUBBLE_VAL;
    end else begin
      r_skid <= w_skid_nxt;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = in_data;
        end
      end
      S_ONE: begin
        // Any in_fire here implies out_ready, so the head is replaced in place.
        if (w_in_fire) begin
          w_main_nxt = in_data;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = BUBBLE_VAL;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
        w_main_nxt  = BUBBLE_VAL;
      end
    endcase
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = BUBBLE_VAL;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_main  <= BUBBLE_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

endmodule
